// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types and constants for the ALU operation sequencer.
//   seq_state_t   : sequencer FSM states (IDLE, EXEC_LO, EXEC_HI, DONE)
//   SEL_LOGIC_BIT : select bit that routes an op to the logic unit
//   OP_W          : width of the ALU select field
//   BYTE_W        : width of one ALU pass
//   WORD_W        : width of a wide (two-pass) operation
//   CNT_W         : width of the ALU latency counter
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC_LO = 2'd1,
        EXEC_HI = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    localparam int SEL_LOGIC_BIT = 2;
    localparam int OP_W          = 3;
    localparam int BYTE_W        = 8;
    localparam int WORD_W        = 16;
    localparam int CNT_W         = 4;

endpackage

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Front-end controller for an 8-bit clocked ALU. Takes one operation per
// request handshake, drives the ALU operand/select lines, waits ALU_LATENCY
// cycles, captures Data/Cout and returns the result on a response handshake.
// Wide (16-bit) operations run as two 8-bit passes, low byte first, with the
// low-pass carry forwarded into the high pass for arithmetic ops.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. A producer holds valid and its payload stable until the transfer;
// ready may be asserted independently of valid.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_op, req_a, req_b,      ALU select, operands (high bytes used only when
//   req_cin, req_wide          req_wide=1), carry-in / logic function select
//   alu_a, alu_b, alu_s,       to the ALU
//   alu_cin
//   alu_data, alu_cout         from the ALU
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_cout         result and final carry-out (0 for logic ops)
//   busy                       high whenever the FSM is not IDLE
//   rsp_zero, rsp_neg          result flags, present only when the macro
//                              ALU_OP_SEQUENCER_FLAGS_EN is defined
//
// Parameter ALU_LATENCY (1..15): cycles from ALU inputs presented to Data/Cout
// valid.
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [WORD_W-1:0] req_a,
    input  logic [WORD_W-1:0] req_b,
    input  logic              req_cin,
    input  logic              req_wide,
    output logic [BYTE_W-1:0] alu_a,
    output logic [BYTE_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_s,
    output logic              alu_cin,
    input  logic [BYTE_W-1:0] alu_data,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_cout,
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    output logic              rsp_zero,
    output logic              rsp_neg,
`endif
    output logic              busy
);

    generate
        if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
            $error("alu_op_sequencer: ALU_LATENCY must be in 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LATENCY - 1);

    seq_state_t          state;
    seq_state_t          state_d;
    logic [CNT_W-1:0]    cnt;
    logic                last;
    logic                accept;
    logic                is_logic;

    logic [OP_W-1:0]     op_q;
    logic [WORD_W-1:0]   a_q;
    logic [WORD_W-1:0]   b_q;
    logic                cin_q;
    logic                wide_q;
    logic [BYTE_W-1:0]   lo_q;
    logic                carry_q;

    logic                cap_en;
    logic [WORD_W-1:0]   cap_word;

    // req_ready is registered so that it reads 0 while reset is asserted;
    // outside reset it always equals (state == IDLE).
    logic                ready_q;

    assign req_ready = ready_q;
    assign accept    = req_valid && ready_q;
    assign last      = (cnt == LAST_CNT);
    assign is_logic  = op_q[SEL_LOGIC_BIT];
    assign busy      = (state != IDLE);

    // The final pass of an operation: low pass of a narrow op, or high pass.
    assign cap_en   = last && (((state == EXEC_LO) && !wide_q) || (state == EXEC_HI));
    assign cap_word = (state == EXEC_HI) ? {alu_data, lo_q}
                                         : {{(WORD_W-BYTE_W){1'b0}}, alu_data};

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_d;
            ready_q <= (state_d == IDLE);
        end
    end

    // ---------------- FSM next state and ALU drive ----------------
    always_comb begin
        state_d = state;
        alu_a   = '0;
        alu_b   = '0;
        alu_s   = '0;
        alu_cin = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_d = EXEC_LO;
            end
            EXEC_LO: begin
                alu_a   = a_q[BYTE_W-1:0];
                alu_b   = b_q[BYTE_W-1:0];
                alu_s   = op_q;
                alu_cin = cin_q;
                if (last) state_d = wide_q ? EXEC_HI : DONE;
            end
            EXEC_HI: begin
                alu_a   = a_q[WORD_W-1:BYTE_W];
                alu_b   = b_q[WORD_W-1:BYTE_W];
                alu_s   = op_q;
                // In the logic unit Cin selects the function, so it must not
                // be replaced by the low-pass carry.
                alu_cin = is_logic ? cin_q : carry_q;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Latency counter ----------------
    // Any state change clears it, so it starts at 0 on entry to each pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_d != state) begin
            cnt <= '0;
        end else if ((state == EXEC_LO) || (state == EXEC_HI)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // ---------------- Request capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            wide_q <= 1'b0;
        end else if (accept) begin
            op_q   <= req_op;
            a_q    <= req_a;
            b_q    <= req_b;
            cin_q  <= req_cin;
            wide_q <= req_wide;
        end
    end

    // ---------------- Result capture and response ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q      <= '0;
            carry_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            if ((state == EXEC_LO) && last) begin
                lo_q    <= alu_data;
                carry_q <= alu_cout;
            end
            if (cap_en) begin
                rsp_valid <= 1'b1;
                rsp_data  <= cap_word;
                rsp_cout  <= is_logic ? 1'b0 : alu_cout;
            end else if ((state == DONE) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero <= 1'b0;
            rsp_neg  <= 1'b0;
        end else if (cap_en) begin
            // Narrow results have a zero high byte, so a 16-bit compare
            // covers both widths.
            rsp_zero <= (cap_word == '0);
            rsp_neg  <= (state == EXEC_HI) ? cap_word[WORD_W-1] : cap_word[BYTE_W-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer with ALU_LATENCY=2 and a behavioural
// 8-bit ALU behind it (one register stage, so Data/Cout become valid two
// cycles after the inputs are first presented).
// ALU model:
//   S[2]=0 : S[1:0]=00 A+Cin, 01 A+B+Cin, 10 A+~B+Cin, 11 A+FF+Cin
//   S[2]=1 : {S[1:0],Cin} = 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 A, 5 ~A, 6 B, 7 ~B
//            Cout from the logic unit is meaningless; the model drives 1.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;
    localparam int L = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_cin;
    logic        req_wide;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_s;
    logic        alu_cin;
    logic [7:0]  alu_data;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_cout;
    logic        busy;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    logic        rsp_zero;
    logic        rsp_neg;
`endif

    int checks;
    int failures;
    logic [16:0] exp_q[$];

    alu_op_sequencer #(.ALU_LATENCY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_wide  (req_wide),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_cin   (alu_cin),
        .alu_data  (alu_data),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
`endif
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU model ----------------
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] s, input logic cin);
        logic [7:0] r;
        logic [7:0] nb;
        nb = ~b;
        if (!s[2]) begin
            case (s[1:0])
                2'd0:    return {1'b0, a} + {8'd0, cin};
                2'd1:    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
                2'd2:    return {1'b0, a} + {1'b0, nb} + {8'd0, cin};
                default: return {1'b0, a} + 9'h0FF + {8'd0, cin};
            endcase
        end
        case ({s[1:0], cin})
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a ^ b);
            3'd4:    r = a;
            3'd5:    r = ~a;
            3'd6:    r = b;
            default: r = ~b;
        endcase
        return {1'b1, r};
    endfunction

    always @(posedge clk) begin
        {alu_cout, alu_data} <= alu_f(alu_a, alu_b, alu_s, alu_cin);
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Called just after a rising edge. Issues one request, follows it through
    // the ALU passes and stops in the first cycle with rsp_valid high.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic wide, input logic [15:0] exp_data,
                          input logic exp_cout, input logic exp_hi_cin);
        int n;
        logic [16:0] exp;
        exp_q.push_back({exp_cout, exp_data});
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_wide  = wide;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = 16'(($urandom_range(0, 65535)));
        req_b     = 16'(($urandom_range(0, 65535)));
        n = 1;
        while (!rsp_valid && n < 40) begin
            if (n == 1) begin
                check("lo_alu_a",   32'(alu_a),   32'(a[7:0]));
                check("lo_alu_b",   32'(alu_b),   32'(b[7:0]));
                check("lo_alu_s",   32'(alu_s),   32'(op));
                check("lo_alu_cin", 32'(alu_cin), 32'(cin));
                check("busy_exec",  32'(busy),    32'd1);
            end
            if (wide && n == L + 1) begin
                check("hi_alu_a",   32'(alu_a),   32'(a[15:8]));
                check("hi_alu_b",   32'(alu_b),   32'(b[15:8]));
                check("hi_alu_cin", 32'(alu_cin), 32'(exp_hi_cin));
            end
            @(posedge clk); #1;
            n++;
        end
        check("rsp_latency", 32'(n), wide ? 32'(2 * L + 1) : 32'(L + 1));
        exp = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(exp[15:0]));
        check("rsp_cout", 32'(rsp_cout), 32'(exp[16]));
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
        check("rsp_zero", 32'(rsp_zero), wide ? 32'(exp[15:0] == 16'h0) : 32'(exp[7:0] == 8'h0));
        check("rsp_neg",  32'(rsp_neg),  wide ? 32'(exp[15]) : 32'(exp[7]));
`endif
    endtask

    // Holds off the response for `hold` cycles, then completes the handshake
    // and returns in the cycle after it.
    task automatic take_rsp(input int hold);
        logic [15:0] held;
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data",  32'(rsp_data),  32'(held));
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
        check("post_busy",      32'(busy),      32'd0);
        check("post_alu_s",     32'(alu_s),     32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int seen;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        req_wide  = 1'b0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Narrow add: 0x12 + 0x34 = 0x46
        run_op(3'b001, 16'h0012, 16'h0034, 1'b0, 1'b0, 16'h0046, 1'b0, 1'b0);
        take_rsp(0);

        // Wide add with carry chain: 0x00FF + 0x0001 = 0x0100
        run_op(3'b001, 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1);
        take_rsp(0);

        // Wide overflow: 0xFFFF + 0x0001 = 0x0000, carry out
        run_op(3'b001, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        take_rsp(0);

        // Wide logic OR (op=100, cin=1); rsp_ready already high beforehand
        rsp_ready = 1'b1;
        run_op(3'b100, 16'h0F0F, 16'h30C0, 1'b1, 1'b1, 16'h3FCF, 1'b0, 1'b1);
        take_rsp(0);

        // Narrow subtract with junk high bytes: 0x50 + ~0x30 + 1 = 0x120
        run_op(3'b010, 16'hAB50, 16'hCD30, 1'b1, 1'b0, 16'h0020, 1'b1, 1'b0);
        take_rsp(5);

        // Back-to-back: accepted the cycle after the handshake. XOR F0^3C=CC
        run_op(3'b101, 16'h00F0, 16'h003C, 1'b0, 1'b0, 16'h00CC, 1'b0, 1'b0);
        take_rsp(1);

        // Reset during the high pass
        req_op    = 3'b001;
        req_a     = 16'h1234;
        req_b     = 16'h1111;
        req_cin   = 1'b0;
        req_wide  = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (L) @(posedge clk);
        #1;
        check("mid_hi_alu_a", 32'(alu_a), 32'h12);
        rst_n = 1'b0;
        #1;
        check("mr_busy",      32'(busy),      32'd0);
        check("mr_alu_a",     32'(alu_a),     32'd0);
        check("mr_alu_b",     32'(alu_b),     32'd0);
        check("mr_alu_cin",   32'(alu_cin),   32'd0);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_rsp_data",  32'(rsp_data),  32'd0);
        check("mr_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_reset", 32'(seen), 32'd0);

        // Normal operation afterwards: 0x00 + 0xFF + 0 = 0xFF
        run_op(3'b011, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0);
        take_rsp(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front-end controller for the 8-bit clocked ALU (operands A/B, carry-in Cin, 3-bit select S, outputs Data/Cout).
- Accepts one operation per valid/ready handshake and drives the ALU operand/select lines.
- Waits the ALU's pipeline latency, captures the result, and returns it on a valid/ready response port.
- Supports 16-bit "wide" operations as two chained 8-bit passes, low byte first, with carry forwarded between passes.

Parameters:
- ALU_LATENCY, 2, cycles from ALU inputs presented to Data/Cout valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  operation request valid.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  ALU select code: bit2=1 logic unit, bit2=0 arithmetic unit.
- req_a  in  16  operand A; bits 15:8 ignored when req_wide=0.
- req_b  in  16  operand B; bits 15:8 ignored when req_wide=0.
- req_cin  in  1  carry-in for arithmetic ops; function-select bit for logic ops.
- req_wide  in  1  1 = 16-bit two-pass operation.
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_s  out  3  to ALU S.
- alu_cin  out  1  to ALU Cin.
- alu_data  in  8  from ALU Data.
- alu_cout  in  1  from ALU Cout.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  16  result; bits 15:8 are zero for narrow ops.
- rsp_cout  out  1  final carry-out; 0 for logic ops.
- busy  out  1  high in any state except IDLE.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). On reset assertion, any operation in flight is abandoned with no response. All outputs reset to 0 and the state machine returns to IDLE.
- States and transitions:
  - IDLE: on accept → EXEC_LO.
  - EXEC_LO: after ALU_LATENCY cycles → EXEC_HI if wide, else DONE.
  - EXEC_HI: after ALU_LATENCY cycles → DONE.
  - DONE: on rsp_ready → IDLE.
- req_ready = (state==IDLE). A request is accepted in cycle T when req_valid & req_ready; the whole request is registered at T.
- EXEC_LO:
  - alu_a/alu_b = low bytes, alu_s = req_op, alu_cin = req_cin.
  - Inputs are presented from cycle T+1 and held stable for ALU_LATENCY cycles.
  - alu_data/alu_cout are sampled in cycle T+ALU_LATENCY into result[7:0] and carry.
- EXEC_HI:
  - alu_a/alu_b = high bytes, alu_s = req_op.
  - alu_cin = captured low-pass carry if op[2]=0; if op[2]=1, alu_cin = req_cin, because Cin is a function select in the logic unit.
  - Inputs are presented from cycle T+ALU_LATENCY+1; the result is sampled at T+2*ALU_LATENCY.
- Response latency: rsp_valid rises at T+ALU_LATENCY+1 (narrow) or T+2*ALU_LATENCY+1 (wide).
- In DONE, rsp_data, rsp_cout and rsp_valid are held stable until rsp_ready. rsp_valid drops the cycle after the handshake.
- Earliest next accept is the cycle after the response handshake; there is no overlap of operations.
- alu_a, alu_b, alu_s and alu_cin are driven to 0 in IDLE and DONE.
- Latency counter:
  - 4 bits wide, cleared on entry to each EXEC state.
  - Saturation is not needed given the parameter range.
  - Elaboration fails if ALU_LATENCY is 0 or greater than 15.
- rsp_cout: alu_cout from the last pass for arithmetic ops; forced 0 for logic ops.
- req_valid deasserting while in a non-IDLE state has no effect.
- rsp_ready held high before rsp_valid is harmless.

Optional Feature:
- Macro: ALU_OP_SEQUENCER_FLAGS_EN.
- When defined: adds output ports rsp_zero (1 bit) and rsp_neg (1 bit), both registered with rsp_data.
  - rsp_zero = (result==0) over the active width (8 or 16 bits).
  - rsp_neg = MSB of the active width.
  - Both reset to 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg contains:
  - State enum (IDLE, EXEC_LO, EXEC_HI, DONE).
  - Select-field constants: SEL_LOGIC_BIT=2, OP_W=3, BYTE_W=8, WORD_W=16.
  - Counter width constant CNT_W=4.
- No sub-module: the FSM, counter and capture registers form a single module.
- The bench instantiates the existing ALU behind the sequencer, or a latency-matched model.

Test Plan:
- Narrow add: op=001 (A+B+Cin), a=0x0012, b=0x0034, cin=0, ALU_LATENCY=2, accept at T → rsp_valid at T+3, rsp_data=0x0046, rsp_cout=0.
- Wide add with carry chain: op=001, a=0x00FF, b=0x0001, cin=0 → hi pass alu_cin=1, rsp_data=0x0100, rsp_cout=0; rsp_valid at T+5.
- Wide overflow: op=001, a=0xFFFF, b=0x0001 → rsp_data=0x0000, rsp_cout=1 (flags build: rsp_zero=1, rsp_neg=0).
- Wide logic op: op=1xx, cin=1 → both passes show alu_cin=1, rsp_cout=0; result matches the byte-wise model.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_data stable, req_ready=0 throughout; a new request is accepted the cycle after the handshake.
- Reset mid-operation: assert rst_n=0 during EXEC_HI → all outputs 0 immediately, no rsp_valid after release; next request completes normally.
